// File: rtl/pcpu_muldiv_pkg.sv
// pcpu_muldiv_pkg: shared FSM state and operation encodings for the iterative mul/div unit.
package pcpu_muldiv_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
    // {op_div, op_signed} as driven by the decoder for MUL/MULS/DIV/DIVS
    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_t;
    function automatic op_t op_code(input logic op_div, input logic op_signed);
        return op_t'({op_div, op_signed});
    endfunction
endpackage

// File: rtl/pcpu_muldiv_if.sv
// pcpu_muldiv_if: request/result bundle between the EX stage and the mul/div unit.
interface pcpu_muldiv_if #(parameter int WIDTH = 16);
    logic             flush;
    logic             start;
    logic             op_div;
    logic             op_signed;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_zero;
    logic             ovf;
    modport master (
        output flush, start, op_div, op_signed, opa, opb,
        input  busy, done, result_lo, result_hi, div_zero, ovf
    );
    modport slave (
        input  flush, start, op_div, op_signed, opa, opb,
        output busy, done, result_lo, result_hi, div_zero, ovf
    );
endinterface

// File: rtl/pcpu_sign_cond.sv
// pcpu_sign_cond: conditional two's-complement negate (abs when neg is the sign bit).
module pcpu_sign_cond #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -a : a;
endmodule

// File: rtl/pcpu_muldiv_unit.sv
// pcpu_muldiv_unit: iterative shift-add multiplier / restoring divider on magnitudes,
// one result bit per cycle, fixed WIDTH+1 cycle latency with sign fix-up in FIN.
module pcpu_muldiv_unit
    import pcpu_muldiv_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          clock,
    input logic          reset,
    pcpu_muldiv_if.slave io
);
    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d, m_q, m_d, lo_q, lo_d, hi_q, hi_d;
    logic               sa_q, sa_d, sb_q, sb_d, dzp_q, dzp_d, ovp_q, ovp_d;
    logic               done_q, done_d, dz_q, dz_d, ov_q, ov_d;
    logic [WIDTH-1:0]   abs_a, abs_b, rem_fix;
    logic [2*WIDTH-1:0] fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   sh, diff;
    logic               nb, is_div;

    assign is_div  = (op_q == OP_DIVU) || (op_q == OP_DIVS);
    assign mul_sum = acc_q + {1'b0, m_q & {WIDTH{q_q[0]}}};
    assign sh      = {acc_q, q_q[WIDTH-1]};
    assign diff    = sh - {2'b00, m_q};
    assign nb      = ~diff[WIDTH+1];

    pcpu_sign_cond #(WIDTH) u_abs_a (.a(io.opa), .neg(io.op_signed & io.opa[WIDTH-1]), .y(abs_a));
    pcpu_sign_cond #(WIDTH) u_abs_b (.a(io.opb), .neg(io.op_signed & io.opb[WIDTH-1]), .y(abs_b));
    // quotient and product share the differing-signs negate; remainder follows the dividend
    pcpu_sign_cond #(2*WIDTH) u_fix (
        .a(is_div ? {{WIDTH{1'b0}}, q_q} : {acc_q[WIDTH-1:0], q_q}),
        .neg(sa_q ^ sb_q),
        .y(fix)
    );
    pcpu_sign_cond #(WIDTH) u_rem (.a(acc_q[WIDTH-1:0]), .neg(sa_q), .y(rem_fix));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dzp_d   = dzp_q;
        ovp_d   = ovp_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (io.start && !io.flush) begin
                state_d = RUN;
                op_d    = op_code(io.op_div, io.op_signed);
                cnt_d   = CNT_W'(WIDTH);
                acc_d   = '0;
                q_d     = abs_a;
                m_d     = abs_b;
                sa_d    = io.op_signed & io.opa[WIDTH-1];
                sb_d    = io.op_signed & io.opb[WIDTH-1];
                dzp_d   = io.op_div && (io.opb == '0);
                ovp_d   = io.op_div && io.op_signed && (io.opa == {1'b1, {(WIDTH-1){1'b0}}}) && (io.opb == '1);
                dz_d    = 1'b0;
                ov_d    = 1'b0;
            end
            RUN: begin
                acc_d   = is_div ? (nb ? diff[WIDTH:0] : sh[WIDTH:0]) : {1'b0, mul_sum[WIDTH:1]};
                q_d     = is_div ? {q_q[WIDTH-2:0], nb} : {mul_sum[0], q_q[WIDTH-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? FIN : RUN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                lo_d    = dzp_q ? '1 : fix[WIDTH-1:0];
                hi_d    = is_div ? rem_fix : fix[2*WIDTH-1:WIDTH];
                dz_d    = dzp_q;
                ov_d    = ovp_q;
            end
            default: state_d = IDLE;
        endcase
        if (io.flush && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
            lo_d    = lo_q;
            hi_d    = hi_q;
            dz_d    = dz_q;
            ov_d    = ov_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULU;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dzp_q   <= 1'b0;
            ovp_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dzp_q   <= dzp_d;
            ovp_q   <= ovp_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign io.busy      = (state_q != IDLE);
    assign io.done      = done_q;
    assign io.result_lo = lo_q;
    assign io.result_hi = hi_q;
    assign io.div_zero  = dz_q;
    assign io.ovf       = ov_q;
endmodule

// File: tb/tb_pcpu_muldiv_unit.sv
// tb_pcpu_muldiv_unit: directed and randomized checks of the mul/div unit against
// an arithmetic reference model (WIDTH=16).
module tb_pcpu_muldiv_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vec = 0;
    int   err = 0;

    pcpu_muldiv_if #(.WIDTH(16)) io ();
    pcpu_muldiv_unit #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .io(io));

    always #5 clock = ~clock;

    typedef struct {
        bit          div;
        bit          sgn;
        logic [15:0] a, b, lo, hi;
        bit          dz, ov;
    } vec_t;

    vec_t tv [8] = '{
        '{0, 0, 16'h0021, 16'h03F5, 16'h8295, 16'h0000, 0, 0},
        '{0, 1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 0, 0},
        '{0, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0},
        '{1, 0, 16'h03F5, 16'h0021, 16'h001E, 16'h0017, 0, 0},
        '{1, 1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 0},
        '{1, 0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0},
        '{1, 1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1},
        '{1, 1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1, 0}
    };

    function automatic void model(input bit div, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] lo, output logic [15:0] hi, output bit dz, output bit ov);
        longint x, y, p, qv, rv;
        x  = sgn ? longint'($signed(a)) : longint'(a);
        y  = sgn ? longint'($signed(b)) : longint'(b);
        dz = 0;
        ov = 0;
        if (!div) begin
            p  = x * y;
            lo = p[15:0];
            hi = p[31:16];
        end else if (b == 16'h0000) begin
            lo = 16'hFFFF;
            hi = a;
            dz = 1;
        end else if (sgn && a == 16'h8000 && b == 16'hFFFF) begin
            lo = 16'h8000;
            hi = 16'h0000;
            ov = 1;
        end else begin
            qv = x / y;
            rv = x % y;
            lo = qv[15:0];
            hi = rv[15:0];
        end
    endfunction

    task automatic start_op(input bit div, input bit sgn, input logic [15:0] a, input logic [15:0] b);
        io.op_div    = div;
        io.op_signed = sgn;
        io.opa       = a;
        io.opb       = b;
        io.start     = 1'b1;
        @(posedge clock);
        #1;
        io.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = io.busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (io.done) begin
                lat = k;
                break;
            end
            bcnt += int'(io.busy);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        vec++;
        if ({io.busy, io.done, io.div_zero, io.ovf, io.result_lo, io.result_hi} !== 36'h0) begin
            err++;
            $display("FAIL reset outputs: got busy=%b done=%b dz=%b ovf=%b lo=%h hi=%h, want all 0",
                     io.busy, io.done, io.div_zero, io.ovf, io.result_lo, io.result_hi);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        vec++;
        if (io.busy !== 1'b0 || io.done !== 1'b0) begin
            err++;
            $display("FAIL reset idle: got busy=%b done=%b, want 0 0", io.busy, io.done);
        end
    endtask

    task automatic test_directed();
        int lat, bcnt;
        logic [15:0] lo_hold;
        foreach (tv[i]) begin
            start_op(tv[i].div, tv[i].sgn, tv[i].a, tv[i].b);
            vec++;
            if (io.div_zero !== 1'b0 || io.ovf !== 1'b0) begin
                err++;
                $display("FAIL dir%0d flags cleared at start: got dz=%b ovf=%b, want 0 0", i, io.div_zero, io.ovf);
            end
            wait_done(lat, bcnt);
            vec++;
            if (lat != 17 || bcnt != 17) begin
                err++;
                $display("FAIL dir%0d timing: got done at E%0d busy %0d cycles, want E17 and 17", i, lat, bcnt);
            end
            vec++;
            if (io.result_lo !== tv[i].lo || io.result_hi !== tv[i].hi) begin
                err++;
                $display("FAIL dir%0d result: got lo=%h hi=%h, want lo=%h hi=%h", i, io.result_lo, io.result_hi, tv[i].lo, tv[i].hi);
            end
            vec++;
            if (io.div_zero !== tv[i].dz || io.ovf !== tv[i].ov) begin
                err++;
                $display("FAIL dir%0d flags: got dz=%b ovf=%b, want dz=%b ovf=%b", i, io.div_zero, io.ovf, tv[i].dz, tv[i].ov);
            end
            lo_hold = tv[i].lo;
            @(posedge clock);
            #1;
            vec++;
            if (io.done !== 1'b0 || io.result_lo !== lo_hold || io.div_zero !== tv[i].dz) begin
                err++;
                $display("FAIL dir%0d hold: got done=%b lo=%h dz=%b, want done=0 lo=%h dz=%b", i, io.done, io.result_lo, io.div_zero, lo_hold, tv[i].dz);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt, r;
        bit div, sgn, dz, ov;
        logic [15:0] a, b, lo, hi;
        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 9);
            div = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            b   = 16'($urandom);
            if (r == 0) b = 16'h0000;
            if (r == 1) begin div = 1; sgn = 1; a = 16'h8000; b = 16'hFFFF; end
            if (r == 2) b = 16'($urandom_range(1, 7));
            model(div, sgn, a, b, lo, hi, dz, ov);
            start_op(div, sgn, a, b);
            wait_done(lat, bcnt);
            vec++;
            if (lat != 17 || io.result_lo !== lo || io.result_hi !== hi || io.div_zero !== dz || io.ovf !== ov) begin
                err++;
                $display("FAIL rand%0d div=%b sgn=%b a=%h b=%h: got lat=%0d lo=%h hi=%h dz=%b ovf=%b, want lat=17 lo=%h hi=%h dz=%b ovf=%b",
                         n, div, sgn, a, b, lat, io.result_lo, io.result_hi, io.div_zero, io.ovf, lo, hi, dz, ov);
            end
        end
    endtask

    task automatic test_handshake();
        int lat = -1, extra = 0;
        start_op(0, 0, 16'h0021, 16'h03F5);
        repeat (4) @(posedge clock);
        #1;
        io.opa   = 16'h0003;
        io.opb   = 16'h0003;
        io.start = 1'b1;
        @(posedge clock);
        #1;
        io.start = 1'b0;
        for (int k = 6; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (io.done) begin
                lat = k;
                break;
            end
        end
        vec++;
        if (lat != 17 || io.result_lo !== 16'h8295) begin
            err++;
            $display("FAIL busy_start ignored: got done at E%0d lo=%h, want E17 lo=8295", lat, io.result_lo);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            extra += int'(io.done) + int'(io.busy);
        end
        vec++;
        if (extra != 0) begin
            err++;
            $display("FAIL busy_start queued: got %0d busy/done cycles afterwards, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        start_op(1, 0, 16'h03F5, 16'h0021);
        wait_done(lat, bcnt);
        vec++;
        if (lat != 17 || io.result_lo !== 16'h001E || io.result_hi !== 16'h0017) begin
            err++;
            $display("FAIL b2b first: got lat=%0d q=%h r=%h, want 17 001e 0017", lat, io.result_lo, io.result_hi);
        end
        start_op(0, 1, 16'hFFFD, 16'h0005);
        wait_done(lat, bcnt);
        vec++;
        if (lat != 17 || bcnt != 17 || io.result_lo !== 16'hFFF1 || io.result_hi !== 16'hFFFF) begin
            err++;
            $display("FAIL b2b second: got lat=%0d busy=%0d lo=%h hi=%h, want 17 17 fff1 ffff", lat, bcnt, io.result_lo, io.result_hi);
        end
    endtask

    task automatic test_flush();
        int lat, bcnt, seen = 0;
        start_op(0, 0, 16'hFFFF, 16'hFFFF);
        wait_done(lat, bcnt);
        start_op(1, 1, 16'hFFF9, 16'h0002);
        repeat (8) @(posedge clock);
        #1 io.flush = 1'b1;
        @(posedge clock);
        #1 io.flush = 1'b0;
        vec++;
        if (io.busy !== 1'b0 || io.done !== 1'b0) begin
            err++;
            $display("FAIL flush abort: got busy=%b done=%b, want 0 0", io.busy, io.done);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            seen += int'(io.done);
        end
        vec++;
        if (seen != 0 || io.result_lo !== 16'h0001 || io.result_hi !== 16'hFFFE) begin
            err++;
            $display("FAIL flush retain: got done pulses=%0d lo=%h hi=%h, want 0 0001 fffe", seen, io.result_lo, io.result_hi);
        end
        io.flush = 1'b1;
        io.start = 1'b1;
        @(posedge clock);
        #1;
        io.flush = 1'b0;
        io.start = 1'b0;
        vec++;
        if (io.busy !== 1'b0) begin
            err++;
            $display("FAIL flush_start idle: got busy=%b, want 0", io.busy);
        end
    endtask

    task automatic test_async_reset();
        int lat, bcnt, seen = 0;
        start_op(0, 0, 16'h1234, 16'h0056);
        repeat (8) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        vec++;
        if ({io.busy, io.done, io.div_zero, io.ovf, io.result_lo, io.result_hi} !== 36'h0) begin
            err++;
            $display("FAIL async reset: got busy=%b done=%b dz=%b ovf=%b lo=%h hi=%h, want all 0",
                     io.busy, io.done, io.div_zero, io.ovf, io.result_lo, io.result_hi);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            seen += int'(io.done);
        end
        vec++;
        if (seen != 0) begin
            err++;
            $display("FAIL reset no done: got %0d done pulses, want 0", seen);
        end
        start_op(1, 1, 16'h8000, 16'hFFFF);
        wait_done(lat, bcnt);
        vec++;
        if (lat != 17 || io.result_lo !== 16'h8000 || io.result_hi !== 16'h0000 || io.ovf !== 1'b1) begin
            err++;
            $display("FAIL post reset op: got lat=%0d q=%h r=%h ovf=%b, want 17 8000 0000 1", lat, io.result_lo, io.result_hi, io.ovf);
        end
    endtask

    initial begin
        io.flush     = 1'b0;
        io.start     = 1'b0;
        io.op_div    = 1'b0;
        io.op_signed = 1'b0;
        io.opa       = '0;
        io.opb       = '0;
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
